us_ping_scheduler: RTL and testbench

Round-robin ranging controller for NUM_SENS ultrasonic sensors that share one echo-width timer. Per ping it fires the selected sensor's trigger, waits for its echo rising edge, measures echo high time in clk cycles, reports the result, then holds off before moving to the next sensor. It sits between the sensor pins and the robot's navigation logic.

---
 rtl/us_ping_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_us_ping_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/us_ping_scheduler.sv
// Round-robin ultrasonic ranging controller: triggers each sensor in turn and times its echo with a shared timer.
// Optional: define US_ECHO_FILTER_EN to pass the selected echo through a 3-sample stability filter.
`timescale 1ns/1ps
module us_ping_scheduler #(
    parameter int NUM_SENS     = 2,
    parameter int TRIG_CYC     = 500,
    parameter int RISE_TO_CYC  = 1_250_000,
    parameter int MAX_ECHO_CYC = 1_250_000,
    parameter int HOLDOFF_CYC  = 500_000,
    parameter int W            = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_SENS-1:0] echo,
    output logic [NUM_SENS-1:0] trig,
    output logic [2:0]          sens_id,
    output logic [W-1:0]        width,
    output logic                valid,
    output logic                timeout,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    localparam logic [W-1:0] TRIG_LAST = W'(TRIG_CYC - 1);
    localparam logic [W-1:0] RISE_LAST = W'(RISE_TO_CYC - 1);
    localparam logic [W-1:0] ECHO_MAX  = W'(MAX_ECHO_CYC);
    localparam logic [W-1:0] HOLD_LAST = W'(HOLDOFF_CYC - 1);
    localparam logic [2:0]   PTR_LAST  = 3'(NUM_SENS - 1);

    genvar gi;

    state_t              state_reg, state_next;
    logic [W-1:0]        timer_reg, timer_next;
    logic [2:0]          ptr_reg, ptr_next;
    logic [NUM_SENS-1:0] sync1_reg, sync2_reg;
    logic [NUM_SENS-1:0] trig_reg, trig_next;
    logic [NUM_SENS-1:0] onehot_next;
    logic [7:0]          sync_pad;
    logic                echo_sel, echo_s, echo_prev_reg, rise;
    logic                report, rep_timeout;
    logic [W-1:0]        rep_width;
    logic [2:0]          sens_id_reg;
    logic [W-1:0]        width_reg;
    logic                valid_reg, timeout_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= echo;
            sync2_reg <= sync1_reg;
        end
    end

    // Pad to 8 lanes so the 3-bit pointer always indexes a legal bit.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pad
            if (gi < NUM_SENS) begin : g_on
                assign sync_pad[gi] = sync2_reg[gi];
            end else begin : g_off
                assign sync_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign echo_sel = sync_pad[ptr_reg];

`ifdef US_ECHO_FILTER_EN
    logic [1:0] hist_reg;
    logic       flt_reg;
    logic       stable;

    // Output follows the input only once three consecutive samples agree.
    assign stable = (echo_sel == hist_reg[0]) && (echo_sel == hist_reg[1]);
    assign echo_s = stable ? echo_sel : flt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= '0;
            flt_reg  <= 1'b0;
        end else begin
            hist_reg <= {hist_reg[0], echo_sel};
            flt_reg  <= echo_s;
        end
    end
`else
    assign echo_s = echo_sel;
`endif

    assign rise = echo_s & ~echo_prev_reg;

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        ptr_next    = ptr_reg;
        report      = 1'b0;
        rep_width   = '0;
        rep_timeout = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (enable) begin
                    state_next = S_TRIG;
                    timer_next = '0;
                end
            end
            S_TRIG: begin
                if (timer_reg == TRIG_LAST) begin
                    state_next = S_WAIT_RISE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + W'(1);
                end
            end
            S_WAIT_RISE: begin
                if (rise) begin
                    state_next = S_MEASURE;
                    timer_next = W'(1);
                end else if (timer_reg == RISE_LAST) begin
                    report      = 1'b1;
                    rep_timeout = 1'b1;
                end else begin
                    timer_next = timer_reg + W'(1);
                end
            end
            S_MEASURE: begin
                // The rise cycle already counted as 1; timer now holds the echo width.
                if (timer_reg == ECHO_MAX) begin
                    report      = 1'b1;
                    rep_timeout = 1'b1;
                    rep_width   = timer_reg;
                end else if (!echo_s) begin
                    report    = 1'b1;
                    rep_width = timer_reg;
                end else begin
                    timer_next = timer_reg + W'(1);
                end
            end
            S_HOLDOFF: begin
                if (timer_reg == HOLD_LAST) begin
                    ptr_next   = (ptr_reg == PTR_LAST) ? 3'd0 : ptr_reg + 3'd1;
                    timer_next = '0;
                    state_next = enable ? S_TRIG : S_IDLE;
                end else begin
                    timer_next = timer_reg + W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase
        if (report) begin
            state_next = S_HOLDOFF;
            timer_next = '0;
        end
    end

    generate
        for (gi = 0; gi < NUM_SENS; gi++) begin : g_trig
            assign onehot_next[gi] = (ptr_next == 3'(gi));
        end
    endgenerate

    assign trig_next = (state_next == S_TRIG) ? onehot_next : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            ptr_reg       <= '0;
            trig_reg      <= '0;
            echo_prev_reg <= 1'b0;
            valid_reg     <= 1'b0;
            sens_id_reg   <= '0;
            width_reg     <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            ptr_reg       <= ptr_next;
            trig_reg      <= trig_next;
            echo_prev_reg <= echo_s;
            valid_reg     <= report;
            if (report) begin
                sens_id_reg <= ptr_reg;
                width_reg   <= rep_width;
                timeout_reg <= rep_timeout;
            end
        end
    end

    assign trig    = trig_reg;
    assign sens_id = sens_id_reg;
    assign width   = width_reg;
    assign valid   = valid_reg;
    assign timeout = timeout_reg;
    assign busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_us_ping_scheduler.sv
// Scoreboard bench for us_ping_scheduler: a sensor model answers each trigger, monitors check reports and trigger pulses.
`timescale 1ns/1ps
module tb_us_ping_scheduler;

    localparam int NS = 2;
    localparam int W  = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [NS-1:0] echo = '0;
    logic [NS-1:0] trig;
    logic [2:0]    sens_id;
    logic [W-1:0]  width;
    logic          valid, timeout, busy;

    us_ping_scheduler #(
        .NUM_SENS(NS), .TRIG_CYC(4), .RISE_TO_CYC(20),
        .MAX_ECHO_CYC(50), .HOLDOFF_CYC(8), .W(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo),
        .trig(trig), .sens_id(sens_id), .width(width),
        .valid(valid), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sid;
        int w;
        int to;
    } rep_t;

    rep_t rq[$];
    int   tq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   valid_cyc = 0;
    int   echo_start[NS];
    int   echo_stop[NS];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Report monitor
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        rep_t e;
        if (rst_n && valid) begin
            valid_cyc = cyc;
            check("valid_one_cycle", int'(valid_prev), 0);
            if (rq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = rq.pop_front();
                check("sens_id", int'(sens_id), e.sid);
                check("width", int'(width), e.w);
                check("timeout", int'(timeout), e.to);
                $display("report sens_id=%0d width=%0d timeout=%0d", sens_id, width, timeout);
            end
        end
        valid_prev = rst_n && valid;
    end

    // Trigger monitor: pulses cut short by reset are discarded
    logic [NS-1:0] tprev = '0;
    int tlen = 0;
    int tsens = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            tlen  = 0;
            tprev = '0;
        end else begin
            if (trig != '0) begin
                if (tprev == '0) begin
                    check("trig_onehot", int'($onehot(trig)), 1);
                    tsens = trig[1] ? 1 : 0;
                    tlen  = 1;
                end else begin
                    tlen++;
                end
            end else if (tprev != '0) begin
                if (tq.size() == 0) begin
                    check("unexpected_trig", 1, 0);
                end else begin
                    check("trig_sensor", tsens, tq.pop_front());
                    check("trig_len", tlen, 4);
                    $display("trig pulse sensor=%0d len=%0d", tsens, tlen);
                end
            end
            tprev = trig;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int s = 0; s < NS; s++)
            echo[s] = (cyc >= echo_start[s]) && (cyc < echo_stop[s]);
    endtask

    // One ping: expect a trigger on s, answer with an echo, wait for the report.
    task automatic do_ping(input int s, input int dly, input int len,
                           input int exp_w, input int exp_to, input bit drop_en);
        rep_t e;
        bit   prev = 1'b0;
        bit   found = 1'b0;
        int   n = 0;
        e.sid = s; e.w = exp_w; e.to = exp_to;
        rq.push_back(e);
        tq.push_back(s);
        while (!found && n < 200) begin
            tick();
            n++;
            if (prev && !trig[s]) found = 1'b1;
            prev = trig[s];
        end
        if (!found) check("trig_fall_wait", 0, 1);
        if (len > 0) begin
            echo_start[s] = cyc + dly;
            echo_stop[s]  = cyc + dly + len;
        end
        if (drop_en) begin
            repeat (dly + 5) tick();
            enable = 1'b0;
        end
        n = 0;
        while (rq.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (rq.size() != 0) begin
            check("report_wait", 0, 1);
            rq.delete();
        end
    endtask

    initial begin
        int n;
        int hits;
        for (int s = 0; s < NS; s++) begin
            echo_start[s] = 0;
            echo_stop[s]  = 0;
        end
        repeat (3) tick();
        check("rst_trig", int'(trig), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_width", int'(width), 0);
        check("rst_sens_id", int'(sens_id), 0);
        check("rst_timeout", int'(timeout), 0);
        #2 rst_n = 1'b1;
        repeat (3) tick();
        check("idle_disabled_busy", int'(busy), 0);

        enable = 1'b1;
        do_ping(0, 5, 30, 30, 0, 1'b0);
        do_ping(1, 3, 10, 10, 0, 1'b0);
        do_ping(0, 2, 1, 1, 0, 1'b0);
        do_ping(1, 0, 0, 0, 1, 1'b0);
        do_ping(0, 4, 80, 50, 1, 1'b0);

        n = 0;
        while (trig == '0 && n < 50) begin
            tick();
            n++;
        end
        check("holdoff_gap", cyc - valid_cyc, 8);

        do_ping(1, 2, 20, 20, 0, 1'b1);
        repeat (10) tick();
        check("idle_after_drop_busy", int'(busy), 0);
        hits = 0;
        repeat (40) begin
            tick();
            if (trig != '0) hits++;
        end
        check("no_trig_when_disabled", hits, 0);

        enable = 1'b1;
        do_ping(0, 3, 7, 7, 0, 1'b0);
        n = 0;
        while (!trig[1] && n < 50) begin
            tick();
            n++;
        end
        check("trig1_seen", int'(trig[1]), 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_trig", int'(trig), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_width", int'(width), 0);
        check("async_rst_timeout", int'(timeout), 0);
        repeat (2) tick();
        #2 rst_n = 1'b1;
        do_ping(0, 2, 12, 12, 0, 1'b0);

        enable = 1'b0;
        repeat (30) tick();
        check("trig_queue_drained", tq.size(), 0);
        check("report_queue_drained", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "global time limit");
    end

endmodule
